// File: rtl/cam_pixel_packer.sv
// Packs RGB565 pixels from the camera converter into 128-bit frame-buffer words,
// with line-end padding, frame/line markers and sticky geometry/overflow flags.
module cam_pixel_packer #(
  parameter int H_ACT = 1280,
  parameter int V_ACT = 720,
  parameter int CNT_W = 12
) (
  input  logic             cam_pclk,
  input  logic             rst_n,
  input  logic             cam_frame_vsync,
  input  logic             cam_frame_href,
  input  logic             cam_frame_valid,
  input  logic [15:0]      cam_frame_data,
  input  logic             fifo_full,
  output logic             out_wr_en,
  output logic [127:0]     out_wr_data,
  output logic             out_frame_start,
  output logic             out_line_end,
  output logic             out_frame_done,
  output logic [CNT_W-1:0] line_cnt,
  output logic             err_line_len,
  output logic             err_overflow
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_LINE = 2'd1,
    ST_ACTIVE    = 2'd2,
    ST_FLUSH     = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_vsync_d;
  logic             r_href_d;
  logic [2:0]       r_lane;
  logic [CNT_W-1:0] r_pix_cnt;
  logic [7:0][15:0] r_pack;
  logic             r_wr_en;
  logic [127:0]     r_wr_data;
  logic             r_frame_start;
  logic             r_line_end;
  logic             r_frame_done;
  logic [CNT_W-1:0] r_line_cnt;
  logic             r_err_line_len;
  logic             r_err_overflow;

  logic             w_vs_rise;
  logic             w_href_fall;
  logic             w_accept;
  logic [CNT_W-1:0] w_line_cnt_inc;
  logic             w_last_line;

  assign w_vs_rise      = cam_frame_vsync & ~r_vsync_d;
  assign w_href_fall    = ~cam_frame_href & r_href_d;
  // The valid in the href-fall cycle is still seen while the state is ACTIVE.
  assign w_accept       = (r_state == ST_ACTIVE) & cam_frame_valid & ~w_vs_rise;
  assign w_line_cnt_inc = r_line_cnt + CNT_W'(1);
  assign w_last_line    = (w_line_cnt_inc == CNT_W'(V_ACT));

  assign out_wr_en       = r_wr_en;
  assign out_wr_data     = r_wr_data;
  assign out_frame_start = r_frame_start;
  assign out_line_end    = r_line_end;
  assign out_frame_done  = r_frame_done;
  assign line_cnt        = r_line_cnt;
  assign err_line_len    = r_err_line_len;
  assign err_overflow    = r_err_overflow;

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync_d <= 1'b0;
      r_href_d  <= 1'b0;
    end else begin
      r_vsync_d <= cam_frame_vsync;
      r_href_d  <= cam_frame_href;
    end
  end

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A vsync rise restarts the frame from any state.
  always_comb begin
    w_state_nxt = r_state;
    if (w_vs_rise) begin
      w_state_nxt = ST_WAIT_LINE;
    end else begin
      case (r_state)
        ST_IDLE:      w_state_nxt = ST_IDLE;
        ST_WAIT_LINE: w_state_nxt = cam_frame_href ? ST_ACTIVE : ST_WAIT_LINE;
        ST_ACTIVE:    w_state_nxt = w_href_fall ? ST_FLUSH : ST_ACTIVE;
        ST_FLUSH:     w_state_nxt = w_last_line ? ST_IDLE : ST_WAIT_LINE;
        default:      w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane         <= 3'd0;
      r_pix_cnt      <= '0;
      r_pack         <= '0;
      r_wr_en        <= 1'b0;
      r_wr_data      <= '0;
      r_frame_start  <= 1'b0;
      r_line_end     <= 1'b0;
      r_frame_done   <= 1'b0;
      r_line_cnt     <= '0;
      r_err_line_len <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      r_wr_en       <= 1'b0;
      r_frame_start <= 1'b0;
      r_line_end    <= 1'b0;
      r_frame_done  <= 1'b0;
      // The packer cannot stall, so a write into a full FIFO is only flagged.
      if (r_wr_en && fifo_full) begin
        r_err_overflow <= 1'b1;
      end
      if (w_vs_rise) begin
        r_frame_start  <= 1'b1;
        r_line_cnt     <= '0;
        r_err_line_len <= 1'b0;
        r_err_overflow <= 1'b0;
        r_lane         <= 3'd0;
        r_pix_cnt      <= '0;
        r_pack         <= '0;
      end else if (w_accept) begin
        if (r_lane == 3'd7) begin
          r_wr_en   <= 1'b1;
          r_wr_data <= {cam_frame_data, r_pack[6:0]};
          r_pack    <= '0;
        end else begin
          r_pack[r_lane] <= cam_frame_data;
        end
        r_lane <= r_lane + 3'd1;
        if (r_pix_cnt != {CNT_W{1'b1}}) begin
          r_pix_cnt <= r_pix_cnt + CNT_W'(1);
        end
      end else if (r_state == ST_FLUSH) begin
        // Lanes past the last pixel are still zero from the previous clear.
        if (r_lane != 3'd0) begin
          r_wr_en   <= 1'b1;
          r_wr_data <= r_pack;
        end
        r_line_end <= 1'b1;
        r_line_cnt <= w_line_cnt_inc;
        if (r_pix_cnt != CNT_W'(H_ACT)) begin
          r_err_line_len <= 1'b1;
        end
        r_frame_done <= w_last_line;
        r_lane       <= 3'd0;
        r_pix_cnt    <= '0;
        r_pack       <= '0;
      end
    end
  end

endmodule
